// File: rtl/pipe_hazard_ctrl_pkg.sv
// ============================================================================
// Module : pipe_ctrl_pkg
// Brief  : Shared types and constants for the pipeline hazard controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MC_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } pipe_state_e;

    // Register x0 is hardwired to zero, so it never creates a true dependency.
    function automatic logic src_matches(
        input logic                 use_src,
        input logic [REG_IDX_W-1:0] src,
        input logic [REG_IDX_W-1:0] dst
    );
        return use_src && (src == dst);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_loaduse_cmp.sv
// ============================================================================
// Module : hz_loaduse_cmp
// Brief  : Combinational load-use hazard detect between ID sources and EX load.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hz_loaduse_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1_i,
    input  logic [REG_IDX_W-1:0] id_rs2_i,
    input  logic                 id_use_rs1_i,
    input  logic                 id_use_rs2_i,
    input  logic [REG_IDX_W-1:0] ex_rd_i,
    input  logic                 ex_mem_read_i,
    output logic                 lu_o
);

    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_rd_valid;

    assign w_rs1_hit  = src_matches(id_use_rs1_i, id_rs1_i, ex_rd_i);
    assign w_rs2_hit  = src_matches(id_use_rs2_i, id_rs2_i, ex_rd_i);
    assign w_rd_valid = (ex_rd_i != REG_X0);

    assign lu_o = ex_mem_read_i && w_rd_valid && (w_rs1_hit || w_rs2_hit);

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module : pipe_hazard_ctrl
// Brief  : Pipeline register sequencer: load-use stalls, branch flushes,
//          multi-cycle EX handshake and stall/flush performance counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MC_TIMEOUT   = 64,
    parameter int CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_branch_taken,
    input  logic                 ex_mc_op,
    input  logic                 mc_done,
    output logic                 mc_start,
    output logic                 pc_wen,
    output logic                 if_id_wen,
    output logic                 if_id_clear,
    output logic                 id_ex_wen,
    output logic                 id_ex_clear,
    output logic                 ex_mem_wen,
    output logic                 ex_mem_clear,
    output logic                 mc_err,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam int               MC_W       = $clog2(MC_TIMEOUT);
    localparam logic [MC_W-1:0]  MC_LAST    = MC_W'(MC_TIMEOUT - 1);
    localparam logic [3:0]       FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    pipe_state_e       state_q,     state_d;
    logic [3:0]        flush_ctr_q, flush_ctr_d;
    logic [MC_W-1:0]   mc_ctr_q,    mc_ctr_d;
    logic              mc_err_q,    mc_err_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;

    logic w_lu;
    logic w_redirect;
    logic w_mc_start;
    logic w_pc_wen;
    logic w_if_id_wen;
    logic w_if_id_clear;
    logic w_id_ex_wen;
    logic w_id_ex_clear;
    logic w_ex_mem_wen;
    logic w_ex_mem_clear;

    hz_loaduse_cmp u_lu_cmp (
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_use_rs1_i  (id_use_rs1),
        .id_use_rs2_i  (id_use_rs2),
        .ex_rd_i       (ex_rd),
        .ex_mem_read_i (ex_mem_read),
        .lu_o          (w_lu)
    );

    // Next-state and raw control decode; priority is mc_op > branch > load-use.
    always_comb begin
        state_d        = state_q;
        flush_ctr_d    = flush_ctr_q;
        mc_ctr_d       = mc_ctr_q;
        mc_err_d       = mc_err_q;
        w_redirect     = 1'b0;
        w_mc_start     = 1'b0;
        w_pc_wen       = 1'b1;
        w_if_id_wen    = 1'b1;
        w_if_id_clear  = 1'b0;
        w_id_ex_wen    = 1'b1;
        w_id_ex_clear  = 1'b0;
        w_ex_mem_wen   = 1'b1;
        w_ex_mem_clear = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (ex_mc_op) begin
                    w_mc_start     = 1'b1;
                    w_pc_wen       = 1'b0;
                    w_if_id_wen    = 1'b0;
                    w_id_ex_wen    = 1'b0;
                    w_ex_mem_clear = 1'b1;
                    mc_ctr_d       = '0;
                    state_d        = ST_MC_WAIT;
                end else if (ex_branch_taken) begin
                    w_redirect    = 1'b1;
                    w_if_id_clear = 1'b1;
                    w_id_ex_clear = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        flush_ctr_d = FLUSH_INIT;
                        state_d     = ST_FLUSH;
                    end
                end else if (w_lu) begin
                    w_pc_wen      = 1'b0;
                    w_if_id_wen   = 1'b0;
                    w_id_ex_clear = 1'b1;
                end
            end

            ST_MC_WAIT: begin
                if (mc_done || (mc_ctr_q == MC_LAST)) begin
                    // Timeout releases exactly like a completion, but flags it.
                    if (!mc_done) begin
                        mc_err_d = 1'b1;
                    end
                    mc_ctr_d = '0;
                    state_d  = ST_RUN;
                end else begin
                    w_pc_wen       = 1'b0;
                    w_if_id_wen    = 1'b0;
                    w_id_ex_wen    = 1'b0;
                    w_ex_mem_clear = 1'b1;
                    mc_ctr_d       = mc_ctr_q + MC_W'(1);
                end
            end

            ST_FLUSH: begin
                w_if_id_clear = 1'b1;
                w_id_ex_clear = 1'b1;
                flush_ctr_d   = flush_ctr_q - 4'd1;
                if (flush_ctr_q <= 4'd1) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_RUN;
            flush_ctr_q <= '0;
            mc_ctr_q    <= '0;
            mc_err_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_ctr_q <= flush_ctr_d;
            mc_ctr_q    <= mc_ctr_d;
            mc_err_q    <= mc_err_d;
            if (!w_pc_wen) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (w_redirect) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    // Controls are forced low for the whole time reset is held.
    assign mc_start     = rstn & w_mc_start;
    assign pc_wen       = rstn & w_pc_wen;
    assign if_id_wen    = rstn & w_if_id_wen;
    assign if_id_clear  = rstn & w_if_id_clear;
    assign id_ex_wen    = rstn & w_id_ex_wen;
    assign id_ex_clear  = rstn & w_id_ex_clear;
    assign ex_mem_wen   = rstn & w_ex_mem_wen;
    assign ex_mem_clear = rstn & w_ex_mem_clear;

    assign mc_err    = mc_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module : tb_pipe_hazard_ctrl
// Brief  : Directed self-checking bench for pipe_hazard_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 32;

    // Control vector: {mc_start, pc_wen, if_id_wen, if_id_clear,
    //                  id_ex_wen, id_ex_clear, ex_mem_wen, ex_mem_clear}
    localparam logic [7:0] C_ZERO = 8'b0000_0000;
    localparam logic [7:0] C_DEF  = 8'b0110_1010;
    localparam logic [7:0] C_LU   = 8'b0000_1110;
    localparam logic [7:0] C_BR   = 8'b0111_1110;
    localparam logic [7:0] C_MCS  = 8'b1000_0011;
    localparam logic [7:0] C_MCW  = 8'b0000_0011;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2, ex_mem_read;
    logic             ex_branch_taken, ex_mc_op, mc_done;
    logic             mc_start, pc_wen, if_id_wen, if_id_clear;
    logic             id_ex_wen, id_ex_clear, ex_mem_wen, ex_mem_clear;
    logic             mc_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [7:0]       ctl;

    int n_cmp = 0;
    int n_err = 0;

    assign ctl = {mc_start, pc_wen, if_id_wen, if_id_clear,
                  id_ex_wen, id_ex_clear, ex_mem_wen, ex_mem_clear};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .FLUSH_CYCLES (3),
        .MC_TIMEOUT   (8),
        .CNT_W        (CNT_W)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .ex_mc_op        (ex_mc_op),
        .mc_done         (mc_done),
        .mc_start        (mc_start),
        .pc_wen          (pc_wen),
        .if_id_wen       (if_id_wen),
        .if_id_clear     (if_id_clear),
        .id_ex_wen       (id_ex_wen),
        .id_ex_clear     (id_ex_clear),
        .ex_mem_wen      (ex_mem_wen),
        .ex_mem_clear    (ex_mem_clear),
        .mc_err          (mc_err),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; ex_mc_op = 1'b0; mc_done = 1'b0;
    endtask

    task automatic set_lu_rs1();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_in();
        rstn = 1'b0;
        #2;
        chk("reset_ctl", ctl, C_ZERO);
        chk("reset_stall", stall_cnt, 0);
        chk("reset_flush", flush_cnt, 0);
        chk("reset_err", mc_err, 0);

        cyc(); rstn = 1'b1; #1;
        chk("idle_ctl", ctl, C_DEF);

        // Load-use on rs1
        cyc(); set_lu_rs1(); #1;
        chk("lu_rs1_ctl", ctl, C_LU);
        cyc(); clr_in(); #1;
        chk("lu_after_ctl", ctl, C_DEF);
        chk("lu_stall", stall_cnt, 1);

        // Same pattern with ex_rd = x0: no hazard
        set_lu_rs1(); ex_rd = 5'd0; id_rs1 = 5'd0; #1;
        chk("lu_x0_ctl", ctl, C_DEF);
        cyc(); clr_in(); #1;
        chk("lu_x0_stall", stall_cnt, 1);

        // Load-use on rs2 only, and the same with use_rs2 cleared
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1; id_rs1 = 5'd5; #1;
        chk("lu_rs2_ctl", ctl, C_LU);
        cyc(); id_use_rs2 = 1'b0; #1;
        chk("lu_rs2_nouse_ctl", ctl, C_DEF);
        chk("lu_rs2_stall", stall_cnt, 2);
        cyc(); clr_in(); #1;

        // Branch redirect, 3 cycles of bubbling
        ex_branch_taken = 1'b1; #1;
        chk("br_c1_ctl", ctl, C_BR);
        chk("br_c1_flush", flush_cnt, 0);
        cyc(); clr_in(); set_lu_rs1(); ex_branch_taken = 1'b1; #1;
        chk("br_c2_ctl_ignore", ctl, C_BR);
        chk("br_c2_flush", flush_cnt, 1);
        cyc(); clr_in(); #1;
        chk("br_c3_ctl", ctl, C_BR);
        chk("br_c3_flush", flush_cnt, 1);
        chk("br_c3_stall", stall_cnt, 2);
        cyc(); #1;
        chk("br_done_ctl", ctl, C_DEF);

        // Branch and load-use together: branch wins
        set_lu_rs1(); ex_branch_taken = 1'b1; #1;
        chk("brlu_ctl", ctl, C_BR);
        cyc(); clr_in(); #1;
        chk("brlu_flush", flush_cnt, 2);
        chk("brlu_stall", stall_cnt, 2);
        cyc(); cyc(); #1;
        chk("brlu_done_ctl", ctl, C_DEF);

        // Multi-cycle op, done on the fifth cycle after start
        ex_mc_op = 1'b1; #1;
        chk("mc_start_ctl", ctl, C_MCS);
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            chk("mc_wait_ctl", ctl, C_MCW);
        end
        cyc(); mc_done = 1'b1; #1;
        chk("mc_done_ctl", ctl, C_DEF);
        chk("mc_done_stall", stall_cnt, 7);
        cyc(); clr_in(); #1;
        chk("mc_after_ctl", ctl, C_DEF);
        chk("mc_after_err", mc_err, 0);

        // mc_done outside MC_WAIT is ignored
        mc_done = 1'b1; #1;
        chk("mc_stray_done_ctl", ctl, C_DEF);
        cyc(); clr_in(); #1;

        // Back-to-back multi-cycle ops
        ex_mc_op = 1'b1; #1;
        chk("b2b_start1", ctl, C_MCS);
        cyc(); #1;
        chk("b2b_wait1", ctl, C_MCW);
        cyc(); mc_done = 1'b1; #1;
        chk("b2b_release1", ctl, C_DEF);
        cyc(); mc_done = 1'b0; #1;
        chk("b2b_start2", ctl, C_MCS);
        chk("b2b_stall", stall_cnt, 9);

        // Second op never completes: timeout after 8 cycles in MC_WAIT
        for (int i = 0; i < 7; i++) begin
            cyc(); #1;
            chk("to_wait_ctl", ctl, C_MCW);
        end
        cyc(); #1;
        chk("to_release_ctl", ctl, C_DEF);
        chk("to_release_err", mc_err, 0);
        chk("to_release_stall", stall_cnt, 17);
        cyc(); clr_in(); #1;
        chk("to_err_set", mc_err, 1);
        chk("to_stall", stall_cnt, 17);
        cyc(); #1;
        chk("to_err_sticky", mc_err, 1);

        // Reset during the third MC_WAIT cycle
        ex_mc_op = 1'b1; #1;
        chk("rst_mc_start", ctl, C_MCS);
        cyc(); cyc(); cyc(); #1;
        chk("rst_mc_wait3", ctl, C_MCW);
        chk("rst_pre_stall", stall_cnt, 20);
        rstn = 1'b0; #1;
        chk("rst_async_ctl", ctl, C_ZERO);
        chk("rst_async_stall", stall_cnt, 0);
        chk("rst_async_flush", flush_cnt, 0);
        chk("rst_async_err", mc_err, 0);
        clr_in();
        cyc(); rstn = 1'b1; #1;
        chk("rst_rel_ctl", ctl, C_DEF);
        cyc(); #1;
        chk("rst_rel2_ctl", ctl, C_DEF);
        chk("rst_rel2_stall", stall_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM).
- Generates per-stage write-enable and clear (bubble) controls for load-use stalls, EX-stage branch redirects and multi-cycle EX operations (mul/div/float).
- Owns the start/done handshake to the multi-cycle unit and keeps stall/flush performance counters.

Parameters:
- FLUSH_CYCLES, 1, cycles of IF/ID bubbling per redirect; legal range 1..15.
- MC_TIMEOUT, 64, maximum MC_WAIT cycles before the error path; must be >= 2.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- id_rs1  in  5  rs1 of the instruction in ID.
- id_rs2  in  5  rs2 of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- ex_mc_op  in  1  instruction in EX needs the multi-cycle unit.
- mc_done  in  1  multi-cycle unit result valid; single-cycle pulse.
- mc_start  out  1  single-cycle start pulse to the multi-cycle unit.
- pc_wen  out  1  PC write enable.
- if_id_wen  out  1  IF/ID write enable.
- if_id_clear  out  1  IF/ID load bubble.
- id_ex_wen  out  1  ID/EX write enable.
- id_ex_clear  out  1  ID/EX load bubble (zero ctrl and instruction).
- ex_mem_wen  out  1  EX/MEM write enable.
- ex_mem_clear  out  1  EX/MEM load bubble.
- mc_err  out  1  sticky flag: multi-cycle timeout occurred.
- stall_cnt  out  CNT_W  number of cycles with pc_wen=0.
- flush_cnt  out  CNT_W  number of redirects taken.

Behaviour:
- Reset (rstn=0, asynchronous):
  - State=RUN; flush_ctr=0; mc_ctr=0; mc_err=0; both perf counters = 0.
  - While rstn=0, every wen, clear and mc_start output is 0.
- Default (no event): all *_wen=1, all *_clear=0, mc_start=0.
- Control outputs are combinational from state and inputs (same-cycle reaction). Counters and mc_err are registered.
- Load-use hazard:
  - lu = ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - Response for exactly that cycle: pc_wen=0, if_id_wen=0, id_ex_clear=1; EX/MEM proceeds normally.
- States:
  - RUN:
    - If ex_mc_op: assert mc_start=1. Hold pc/if_id/id_ex (wen=0). ex_mem_clear=1. Next state MC_WAIT. mc_ctr=0.
    - Else if ex_branch_taken: pc_wen=1 (loads target), if_id_clear=1, id_ex_clear=1, flush_cnt+1. Next state FLUSH if FLUSH_CYCLES>1 (flush_ctr=FLUSH_CYCLES-1), otherwise stay in RUN.
    - Else if lu: apply the load-use response.
  - MC_WAIT:
    - Hold pc/if_id/id_ex (wen=0) and assert ex_mem_clear=1 so MEM/WB drain.
    - mc_ctr increments each cycle.
    - On mc_done=1: all wen=1, no clears (the result advances into EX/MEM); next state RUN.
    - If mc_ctr reaches MC_TIMEOUT-1 without mc_done: set mc_err, release as if done, go to RUN.
  - FLUSH:
    - pc_wen=1, if_id_clear=1, id_ex_clear=1.
    - flush_ctr decrements; go to RUN when it reaches 1.
    - lu and ex_branch_taken are ignored in FLUSH (ID/EX hold bubbles).
- Priority (simultaneous events): mc_op > branch > load-use.
  - ex_branch_taken is ignored while ex_mc_op=1; the two are mutually exclusive by decode.
  - Branch plus lu in the same cycle: branch wins and the ID instruction is flushed.
- mc_done outside MC_WAIT is ignored. mc_start is never asserted in two consecutive cycles.
- The ex_mc_op instruction after release is a new instruction, so back-to-back multi-cycle ops re-enter MC_WAIT the next cycle with a fresh start pulse.
- stall_cnt increments in every non-reset cycle with pc_wen=0.
- Both perf counters wrap modulo 2^CNT_W.
- Reset asserted mid-MC_WAIT or mid-FLUSH: state returns to RUN immediately and outputs are forced to 0. No pending start or flush survives reset.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - State enum {RUN, MC_WAIT, FLUSH}, 2 bits.
  - Register-index width constant REG_IDX_W=5.
  - x0 index constant.
- One sub-module, hz_loaduse_cmp: combinational lu detect from rs1/rs2/use/ex_rd/ex_mem_read.
- FSM, counters and output decode live in the top module.

Test Plan:
- ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> exactly one cycle of pc_wen=0, if_id_wen=0, id_ex_clear=1; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- ex_branch_taken=1 with FLUSH_CYCLES=3 -> if_id_clear=1 and id_ex_clear=1 for 3 consecutive cycles, pc_wen=1 throughout; flush_cnt=1; then RUN.
- ex_mc_op=1, mc_done arrives 5 cycles later -> mc_start high 1 cycle, pc_wen=0 for 5 cycles, ex_mem_clear=1 while waiting; all wen=1 on the done cycle; stall_cnt=5.
- ex_mc_op=1 with mc_done never asserted, MC_TIMEOUT=8 -> release after 8 cycles in MC_WAIT, mc_err=1 and stays set until reset.
- Branch and load-use hazard in the same cycle -> flush response only, no pc stall; flush_cnt increments, stall_cnt unchanged.
- rstn driven low during cycle 3 of MC_WAIT -> all outputs 0 asynchronously; after release state is RUN, counters are 0 and mc_start does not re-pulse without ex_mc_op.
